// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader
// and the core-side write port it drives.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_DONE
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    localparam logic [1:0] LANE_FIRST = 2'd0;
    localparam logic [1:0] LANE_LAST  = 2'd3;

    localparam int IMEM_ADDR_W = 32;
    localparam int IMEM_DATA_W = 32;

    function automatic logic [IMEM_ADDR_W-1:0] word_to_byte_addr(
        input logic [15:0] idx
    );
        return {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs a byte stream little-endian into 32-bit words; the fourth
// byte completes the word combinationally alongside word_valid.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  lane;
    logic [23:0] shreg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lane  <= LANE_FIRST;
            shreg <= '0;
        end else if (byte_valid) begin
            lane  <= lane + 2'd1;
            shreg <= {byte_data, shreg[23:8]};
        end
    end

    // After three bytes shreg holds {b2,b1,b0}; the live byte is b3.
    assign word_valid = byte_valid && (lane == LANE_LAST);
    assign word       = {byte_data, shreg};

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory; holds the core
// in reset until the whole image has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 10,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic                   mem_we,
    output logic [IMEM_ADDR_W-1:0] mem_addr,
    output logic [IMEM_DATA_W-1:0] mem_wdata,
    output logic                   cpu_rst,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

    state_t      state;
    state_t      state_next;
    logic [7:0]  cnt_lo;
    logic [15:0] count;
    logic [15:0] word_index;
    logic        accept;
    logic        is_sync;
    logic        in_range;
    logic        last_word;
    logic        lane_clear;
    logic        byte_valid;
    logic        word_valid;
    logic [31:0] word;

    assign accept     = s_valid && s_ready;
    assign is_sync    = (s_data == SYNC_BYTE);
    assign in_range   = ({1'b0, word_index} < DEPTH);
    assign last_word  = ((word_index + 16'd1) == count);
    assign byte_valid = accept && (state == ST_DATA);

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (lane_clear),
        .byte_valid (byte_valid),
        .byte_data  (s_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        lane_clear = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                done = (state == ST_DONE);
                if (accept && is_sync) state_next = ST_LEN0;
            end
            ST_LEN0: begin
                busy = 1'b1;
                if (accept) state_next = ST_LEN1;
            end
            ST_LEN1: begin
                busy = 1'b1;
                if (accept) begin
                    lane_clear = 1'b1;
                    if ({s_data, cnt_lo} == 16'd0) state_next = ST_DONE;
                    else                           state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                busy = 1'b1;
                if (word_valid && last_word) state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
        cpu_rst = !done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_ready    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            err        <= 1'b0;
            cnt_lo     <= '0;
            count      <= '0;
            word_index <= '0;
        end else begin
            s_ready <= 1'b1;
            mem_we  <= 1'b0;
            if (state == ST_LEN0 && accept) cnt_lo <= s_data;
            if (state == ST_LEN1 && accept) begin
                count      <= {s_data, cnt_lo};
                word_index <= '0;
                err        <= 1'b0;
            end
            // Words past the end of memory are consumed but never written.
            if (word_valid) begin
                word_index <= word_index + 16'd1;
                if (in_range) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= word_to_byte_addr(word_index);
                    mem_wdata <= word;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: two instances
// (depth 1024 and depth 4) against a byte-level frame parser model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;

    logic        rdy  [2];
    logic        we   [2];
    logic [31:0] addr [2];
    logic [31:0] wd   [2];
    logic        crst [2];
    logic        bsy  [2];
    logic        dn   [2];
    logic        er   [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(10)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
        .s_ready(rdy[0]), .mem_we(we[0]), .mem_addr(addr[0]),
        .mem_wdata(wd[0]), .cpu_rst(crst[0]), .busy(bsy[0]),
        .done(dn[0]), .err(er[0])
    );

    imem_loader #(.ADDR_WIDTH(2)) dut_s (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
        .s_ready(rdy[1]), .mem_we(we[1]), .mem_addr(addr[1]),
        .mem_wdata(wd[1]), .cpu_rst(crst[1]), .busy(bsy[1]),
        .done(dn[1]), .err(er[1])
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural frame parser: header byte count, data byte count.
    int          m_depth [2] = '{1024, 4};
    bit          m_live = 1'b0;
    bit          m_rdy   [2];
    bit          m_frame [2];
    bit          m_done  [2];
    bit          m_err   [2];
    bit          m_we    [2];
    int          m_hdr   [2];
    int          m_cnt   [2];
    int          m_nb    [2];
    logic [31:0] m_word  [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wd    [2];

    task automatic model_byte(input int k, input logic [7:0] b);
        int idx;
        if (!m_frame[k]) begin
            if (b == 8'hA5) begin
                m_frame[k] = 1'b1;
                m_done[k]  = 1'b0;
                m_hdr[k]   = 0;
            end
        end else if (m_hdr[k] == 0) begin
            m_cnt[k] = int'(b);
            m_hdr[k] = 1;
        end else if (m_hdr[k] == 1) begin
            m_cnt[k]  = m_cnt[k] + 256 * int'(b);
            m_hdr[k]  = 2;
            m_nb[k]   = 0;
            m_word[k] = 32'h0;
            m_err[k]  = 1'b0;
            if (m_cnt[k] == 0) begin
                m_frame[k] = 1'b0;
                m_done[k]  = 1'b1;
            end
        end else begin
            m_word[k] = m_word[k] | (32'(b) << (8 * (m_nb[k] % 4)));
            m_nb[k]++;
            if (m_nb[k] % 4 == 0) begin
                idx = m_nb[k] / 4 - 1;
                if (idx < m_depth[k]) begin
                    m_we[k]   = 1'b1;
                    m_addr[k] = 32'(idx * 4);
                    m_wd[k]   = m_word[k];
                end else begin
                    m_err[k] = 1'b1;
                end
                m_word[k] = 32'h0;
                if (m_nb[k] / 4 == m_cnt[k]) begin
                    m_frame[k] = 1'b0;
                    m_done[k]  = 1'b1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        m_live = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_rdy[k] = 0; m_frame[k] = 0; m_done[k] = 0;
                m_err[k] = 0; m_we[k] = 0; m_hdr[k] = 0;
                m_addr[k] = 0; m_wd[k] = 0;
            end else begin
                m_we[k] = 1'b0;
                if (m_rdy[k] && s_valid) model_byte(k, s_data);
                m_rdy[k] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("s_ready[%0d]", k), 32'(rdy[k]), 32'(m_rdy[k]));
                chk($sformatf("mem_we[%0d]", k), 32'(we[k]), 32'(m_we[k]));
                chk($sformatf("done[%0d]", k), 32'(dn[k]), 32'(m_done[k]));
                chk($sformatf("cpu_rst[%0d]", k), 32'(crst[k]),
                    32'(!m_done[k]));
                chk($sformatf("busy[%0d]", k), 32'(bsy[k]), 32'(m_frame[k]));
                chk($sformatf("err[%0d]", k), 32'(er[k]), 32'(m_err[k]));
                if (m_we[k]) begin
                    chk($sformatf("mem_addr[%0d]", k), addr[k], m_addr[k]);
                    chk($sformatf("mem_wdata[%0d]", k), wd[k], m_wd[k]);
                end
            end
        end
    end

    // Instruction memories written through the loader's port.
    logic [31:0] mem0 [1024];
    logic [31:0] mem1 [4];
    int          wcnt [2] = '{0, 0};
    bit          log_on = 1'b0;
    logic [63:0] logq [$];

    always @(posedge clk) begin
        if (we[0]) begin
            mem0[addr[0][11:2]] = wd[0];
            wcnt[0]++;
            if (log_on) logq.push_back({addr[0], wd[0]});
        end
        if (we[1]) begin
            mem1[addr[1][3:2]] = wd[1];
            wcnt[1]++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic put(input logic [7:0] b, input bit gappy);
        if (gappy) idle($urandom_range(0, 1));
        s_valid = 1'b1;
        s_data  = b;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_q(input logic [7:0] q[$], input bit gappy);
        foreach (q[i]) put(q[i], gappy);
    endtask

    task automatic reset_checks(input int k);
        chk("rst s_ready", 32'(rdy[k]), 32'd0);
        chk("rst mem_we", 32'(we[k]), 32'd0);
        chk("rst mem_addr", addr[k], 32'd0);
        chk("rst mem_wdata", wd[k], 32'd0);
        chk("rst cpu_rst", 32'(crst[k]), 32'd1);
        chk("rst busy", 32'(bsy[k]), 32'd0);
        chk("rst done", 32'(dn[k]), 32'd0);
        chk("rst err", 32'(er[k]), 32'd0);
    endtask

    task automatic build_frame(input int n, output logic [7:0] q[$]);
        q = {};
        q.push_back(8'hA5);
        q.push_back(8'(n));
        q.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  q[$];
        logic [63:0] ref_log[$];
        int          w0;
        int          w1;

        @(negedge clk);
        repeat (2) @(negedge clk);
        reset_checks(0);
        reset_checks(1);
        rst = 1'b0;
        idle(3);

        // Two-word image.
        w0 = wcnt[0];
        send_q('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00}, 1'b0);
        idle(3);
        chk("t1 mem[0]", mem0[0], 32'h0000_0013);
        chk("t1 mem[1]", mem0[1], 32'h0010_0093);
        chk("t1 writes", 32'(wcnt[0] - w0), 32'd2);
        chk("t1 done", 32'(dn[0]), 32'd1);
        chk("t1 cpu_rst", 32'(crst[0]), 32'd0);

        // Junk bytes then empty frame.
        w0 = wcnt[0];
        send_q('{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00}, 1'b0);
        idle(2);
        chk("t2 writes", 32'(wcnt[0] - w0), 32'd0);
        chk("t2 done", 32'(dn[0]), 32'd1);
        chk("t2 err", 32'(er[0]), 32'd0);

        // Random frames: gap-free and gappy runs must write identically.
        for (int t = 0; t < 6; t++) begin
            build_frame($urandom_range(1, 7), q);
            repeat ($urandom_range(0, 3)) put(8'($urandom_range(0, 8'hA4)), 1'b0);
            logq = {};
            log_on = 1'b1;
            send_q(q, 1'b0);
            idle(2);
            ref_log = logq;
            logq = {};
            send_q(q, 1'b1);
            idle(2);
            log_on = 1'b0;
            chk("gap log size", 32'(logq.size()), 32'(ref_log.size()));
            for (int i = 0; i < ref_log.size() && i < logq.size(); i++)
                chk("gap log entry", logq[i][31:0], ref_log[i][31:0]);
        end

        // Five words into a four-word memory.
        w0 = wcnt[0];
        w1 = wcnt[1];
        build_frame(5, q);
        send_q(q, 1'b0);
        idle(2);
        chk("ovf writes small", 32'(wcnt[1] - w1), 32'd4);
        chk("ovf writes big", 32'(wcnt[0] - w0), 32'd5);
        chk("ovf err small", 32'(er[1]), 32'd1);
        chk("ovf done small", 32'(dn[1]), 32'd1);
        chk("ovf err big", 32'(er[0]), 32'd0);

        // Reset in the middle of word 1 of a three-word frame.
        send_q('{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                 8'h55, 8'h66}, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        reset_checks(0);
        reset_checks(1);
        rst = 1'b0;
        idle(2);
        send_q('{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}, 1'b0);
        idle(2);
        chk("rst reload mem[0]", mem0[0], 32'h1234_5678);
        chk("rst reload done", 32'(dn[0]), 32'd1);

        // Reload from DONE.
        put(8'hA5, 1'b0);
        chk("reload cpu_rst", 32'(crst[0]), 32'd1);
        chk("reload busy", 32'(bsy[0]), 32'd1);
        send_q('{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 1'b1);
        idle(2);
        chk("reload mem[0]", mem0[0], 32'hDEAD_BEEF);
        chk("reload cpu_rst low", 32'(crst[0]), 32'd0);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
